// File: rtl/vram_patgen.sv
// ---------------------------------------------------------------------------
// vram_patgen
//
// Write-side source for the LCD frame VRAM. In pass-through mode it forwards
// the video sampler's pixel writes to the VRAM write port with one registered
// cycle of latency. In pattern modes it sweeps a built-in test pattern over
// the whole WIDTH x HEIGHT frame, one pixel per clock, x inner / y outer.
// Mode changes are only taken at frame boundaries (frame_start pulses), so a
// sweep in progress always completes with the pattern it started with.
//
// Optional feature macro: PATGEN_ANIM_EN
//   defined   : the x coordinate used by the patterns is offset by a frame
//               counter and every frame boundary in DONE with a non-zero
//               mode re-sweeps, giving a scrolling image.
//   undefined : patterns use the plain x coordinate and DONE only re-sweeps
//               when the newly latched mode differs from the previous one.
//
// Ports
//   clk_12m      in   block clock, all logic on the rising edge
//   rstn         in   synchronous active-low reset
//   mode         in   requested mode: 0 pass, 1 solid, 2 vbars, 3 checker,
//                     4 vertical gradient, 5-7 blank
//   frame_start  in   one-cycle pulse per input frame
//   samp_we      in   sampler write strobe
//   samp_addr    in   sampler write address {y,x}
//   samp_data    in   sampler pixel
//   vram_we      out  VRAM write enable
//   vram_addr    out  VRAM write address {y,x}
//   vram_data    out  VRAM write data
//   busy         out  high on every sweep write cycle
//   sweep_done   out  one-cycle pulse with the last sweep write
// ---------------------------------------------------------------------------
module vram_patgen #(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 8,
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 144,
  parameter int BPP       = 2,
  parameter int BAR_SHIFT = 4,
  parameter int CHK_SHIFT = 3
) (
  input  logic                     clk_12m,
  input  logic                     rstn,
  input  logic [2:0]               mode,
  input  logic                     frame_start,
  input  logic                     samp_we,
  input  logic [X_BITS+Y_BITS-1:0] samp_addr,
  input  logic [BPP-1:0]           samp_data,
  output logic                     vram_we,
  output logic [X_BITS+Y_BITS-1:0] vram_addr,
  output logic [BPP-1:0]           vram_data,
  output logic                     busy,
  output logic                     sweep_done
);

  // The row accumulator must hold up to HEIGHT-1 plus one step of 2**BPP
  // before it is folded back, which always fits in Y_BITS+BPP bits.
  localparam int                ACC_W    = Y_BITS + BPP;
  localparam logic [X_BITS-1:0] X_LAST   = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST   = Y_BITS'(HEIGHT - 1);
  localparam logic [ACC_W-1:0]  ACC_STEP = ACC_W'(2 ** BPP);
  localparam logic [ACC_W-1:0]  ACC_WRAP = ACC_W'(HEIGHT);
  localparam logic [BPP-1:0]    LVL_MAX  = {BPP{1'b1}};

  typedef enum logic [1:0] {
    ST_PASS,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [2:0]               mode_q;
  logic [2:0]               mode_q_n;
  logic                     pend;
  logic                     pend_n;
  logic [X_BITS-1:0]        x;
  logic [X_BITS-1:0]        x_n;
  logic [Y_BITS-1:0]        y;
  logic [Y_BITS-1:0]        y_n;
  logic [BPP-1:0]           level;
  logic [BPP-1:0]           level_n;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_n;
  logic [ACC_W-1:0]         acc_sum;
  logic                     we_n;
  logic                     busy_n;
  logic                     done_n;
  logic [X_BITS+Y_BITS-1:0] addr_n;
  logic [BPP-1:0]           data_n;
  logic [BPP-1:0]           pix;
  logic [X_BITS-1:0]        xp;
  logic                     resweep;
  logic                     last_x;
  logic                     last_y;

`ifdef PATGEN_ANIM_EN
  logic [X_BITS-1:0] frame_cnt;

  // Free-running frame counter that drives the scrolling offset. It counts
  // every frame boundary regardless of state and simply wraps.
  always_ff @(posedge clk_12m) begin
    if (!rstn) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign xp      = x + frame_cnt;
  assign resweep = 1'b1;
`else
  assign xp      = x;
  assign resweep = (mode != mode_q);
`endif

  assign last_x  = (x == X_LAST);
  assign last_y  = (y == Y_LAST);
  assign acc_sum = acc + ACC_STEP;

  // Pattern generator: pure function of the latched mode, the (possibly
  // offset) x coordinate, y and the gradient level. Field extraction uses
  // shifts so the bit position is purely a parameter choice.
  always_comb begin
    pix = '0;
    case (mode_q)
      3'd1:    pix = LVL_MAX;
      3'd2:    pix = BPP'(xp >> BAR_SHIFT);
      3'd3:    pix = BPP'(xp >> CHK_SHIFT) ^ BPP'(y >> CHK_SHIFT);
      3'd4:    pix = level;
      default: pix = '0;
    endcase
  end

  // Next-state and next-output logic. Outputs are fully registered, so this
  // block decides what the write port will present after the coming edge.
  // In SWEEP the gradient level is stepped once per row with an accumulator
  // (level = floor(y * 2**BPP / HEIGHT)) so no divider is needed.
  always_comb begin
    state_n  = state;
    mode_q_n = mode_q;
    pend_n   = pend;
    x_n      = x;
    y_n      = y;
    level_n  = level;
    acc_n    = acc;
    we_n     = 1'b0;
    addr_n   = '0;
    data_n   = '0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      ST_PASS: begin
        we_n   = samp_we;
        addr_n = samp_addr;
        data_n = samp_data;
        if (frame_start && (mode != 3'd0)) begin
          mode_q_n = mode;
          state_n  = ST_SWEEP;
          x_n      = '0;
          y_n      = '0;
          level_n  = '0;
          acc_n    = '0;
        end
      end

      ST_SWEEP: begin
        we_n   = 1'b1;
        busy_n = 1'b1;
        addr_n = {y, x};
        data_n = pix;
        if (frame_start) begin
          pend_n = 1'b1;
        end
        if (last_x) begin
          x_n = '0;
          if (acc_sum >= ACC_WRAP) begin
            acc_n = acc_sum - ACC_WRAP;
            if (level != LVL_MAX) begin
              level_n = level + 1'b1;
            end
          end else begin
            acc_n = acc_sum;
          end
          if (last_y) begin
            y_n     = '0;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            y_n = y + 1'b1;
          end
        end else begin
          x_n = x + 1'b1;
        end
      end

      ST_DONE: begin
        if (frame_start || pend) begin
          pend_n   = 1'b0;
          mode_q_n = mode;
          if (mode == 3'd0) begin
            state_n = ST_PASS;
          end else if (resweep) begin
            state_n = ST_SWEEP;
            x_n     = '0;
            y_n     = '0;
            level_n = '0;
            acc_n   = '0;
          end
        end
      end

      default: begin
        state_n = ST_PASS;
      end
    endcase
  end

  // State, sweep position, gradient and output registers. Reset returns the
  // block to pass-through with every output low, even in the middle of a
  // sweep.
  always_ff @(posedge clk_12m) begin
    if (!rstn) begin
      state      <= ST_PASS;
      mode_q     <= '0;
      pend       <= 1'b0;
      x          <= '0;
      y          <= '0;
      level      <= '0;
      acc        <= '0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      mode_q     <= mode_q_n;
      pend       <= pend_n;
      x          <= x_n;
      y          <= y_n;
      level      <= level_n;
      acc        <= acc_n;
      vram_we    <= we_n;
      vram_addr  <= addr_n;
      vram_data  <= data_n;
      busy       <= busy_n;
      sweep_done <= done_n;
    end
  end

endmodule
